seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
Parametrised multi-channel seven-segment scan driver for the board top level. It selects one of NUM_CH 32-bit-class debug sources (PC, instr, register taps) with a switch input. It latches that source once per refresh frame and time-multiplexes DIGITS hex digits onto shared segment/select lines. It generalises a single-source 8-digit display: configurable digit count, channel count and refresh rate, plus frame-coherent snapshotting and an enable/blank mode.

Parameters:
NUM_CH, 4, number of selectable source channels (>=2)
DIGITS, 8, number of scanned digits (1..8); each channel carries DIGITS*4 bits
DIV, 100000, clk cycles per digit slot (>=2)
CH_W, $clog2(NUM_CH), width of ch_sel (localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
ena  in  1  scan enable; low = blank outputs, hold counters
ch_sel  in  CH_W  source channel select
ch_data  in  NUM_CH*DIGITS*4  packed sources; channel c = ch_data[c*DIGITS*4 +: DIGITS*4]
o_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
o_sel  out  DIGITS  digit anode select, active-low, one-hot-low when lit

Behaviour:
- Reset (rst==0 at posedge): prescaler=0, digit_idx=0, snapshot=0, o_seg=8'hFF, o_sel=all ones. Reset has priority over ena and applies mid-frame with no residue.
- Prescaler counts 0..DIV-1 while ena=1. tick is asserted in the cycle in which prescaler==DIV-1; the prescaler then wraps to 0.
- On tick: digit_idx <= (digit_idx==DIGITS-1) ? 0 : digit_idx+1.
- Snapshot: when tick occurs and digit_idx==DIGITS-1 (frame wrap), snapshot <= channel ch_sel of ch_data. The first snapshot after reset also loads on the first clock with ena=1 and rst=1.
- A ch_sel change mid-frame takes effect only at the next frame wrap, so no torn frames. ch_sel >= NUM_CH selects channel 0.
- Outputs are registered. Each cycle with ena=1: o_sel <= ~(1<<digit_idx) and o_seg <= ~{1'b0, hexdec(snapshot[digit_idx*4 +: 4])}. Outputs therefore lag digit_idx by 1 cycle.
- Digit 0 is the rightmost digit and the least-significant nibble.
- The dp segment is always off (o_seg[7]=1).
- hexdec uses the standard 0-F patterns, with A,b,C,d,E,F for nibbles 10-15.
- ena=0: prescaler, digit_idx and snapshot hold; next cycle o_seg=8'hFF and o_sel=all ones. When ena rises, scanning resumes from the held digit_idx and prescaler value.
- Frame period = DIGITS*DIV cycles. No digit is ever lit for less than DIV-1 cycles except at ena/reset edges.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: at snapshot load, compute lz = index of the most-significant nonzero nibble. Digits above lz are blanked (o_sel bit still driven low, o_seg=8'hFF). Digit 0 is always shown, so a value of 0 displays a single "0".
- Undefined: all DIGITS digits are shown, including leading zeros. No extra registers are created.

Decomposition:
- Shared package seg7_pkg holds the 16-entry segment pattern constant (active-high, {g..a}) and the hexdec function, so the same table is reused by other display blocks.
- One sub-module, seg7_prescaler (parametrised DIV, outputs tick, honours ena and rst), is natural. The digit counter, snapshot and output registers stay in the top.

Test Plan:
1. DIGITS=4, DIV=4, rst low 3 cycles, then high, ena=1, ch0=16'h1234, ch_sel=0 -> o_sel cycles E,D,B,7 every 4 clks; o_seg shows the patterns for 4,3,2,1 (0x99, 0xB0, 0xA4, 0xF9).
2. Switch ch_sel 0->1 (ch1=16'hABCD) at digit 1 -> remainder of the frame still shows 1234; the next frame, starting at o_sel=E, shows D,C,b,A (0xA1, 0xC6, 0x83, 0x88).
3. ena=0 for 10 cycles mid-digit -> o_seg=FF and o_sel=F from the next cycle; after ena=1, the same digit resumes and the remaining slot length equals the remaining prescaler count.
4. Assert rst low mid-frame for 1 cycle -> next cycle o_seg=FF and o_sel=F; after release, digit 0 is shown with the snapshot loaded from current ch_data.
5. ch_sel=3 with NUM_CH=3 -> displays channel 0 data.
6. With SEG7_LEADING_ZERO_BLANK_EN defined and data 16'h0050 -> digits 3 and 2 blank (o_seg=FF), digit 1=5 (0x92), digit 0=0 (0xC0). With data 0 -> only digit 0 shows 0xC0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment helpers: active-high {g..a} glyph table for hex digits 0-F
// and the hexdec lookup. Reused by any block that drives a 7-segment display.
package seg7_pkg;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hexdec(input logic [3:0] nib);
    return SEG_PAT[nib];
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 while ena is high and pulses tick on the
// last count. The count holds while ena is low.
module seg7_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = ena && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst)      count <= '0;
    else if (tick) count <= '0;
    else if (ena)  count <= count + 1'b1;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multi-channel seven-segment scan driver with frame-coherent source snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DIGITS = 8,
  parameter  int DIV    = 100000,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [CH_W-1:0]              ch_sel,
  input  logic [NUM_CH*DIGITS*4-1:0]   ch_data,
  output logic [7:0]                   o_seg,
  output logic [DIGITS-1:0]            o_sel
);

  localparam int CH_BITS = DIGITS * 4;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic               tick;
  logic [IDX_W-1:0]   digit_idx;
  logic [CH_BITS-1:0] snapshot;
  logic [CH_BITS-1:0] src;
  logic               first_load;
  logic               load;
  logic               blank;
  logic [3:0]         nibble;
  logic [7:0]         seg_next;

  seg7_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .tick (tick)
  );

  // Out-of-range selects fall back to channel 0.
  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    src = ch_data[CH_BITS-1:0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (ch_sel == CH_W'(c)) src = ch_data[c*CH_BITS +: CH_BITS];
    end
  end

  assign load = ena && (first_load || (tick && (digit_idx == LAST_IDX)));

  always_ff @(posedge clk) begin
    if (!rst)      digit_idx <= '0;
    else if (tick) digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
  end

  // first_load makes the display valid on the first enabled clock after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snapshot   <= '0;
      first_load <= 1'b1;
    end else begin
      if (load) snapshot <= src;
      if (ena)  first_load <= 1'b0;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] lz;
  logic [IDX_W-1:0] lz_next;

  always_comb begin
    lz_next = '0;
    for (int d = 1; d < DIGITS; d++) begin
      if (src[d*4 +: 4] != 4'h0) lz_next = IDX_W'(d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)      lz <= '0;
    else if (load) lz <= lz_next;
  end

  assign blank = (digit_idx > lz);
`else
  assign blank = 1'b0;
`endif

  assign nibble   = snapshot[{digit_idx, 2'b00} +: 4];
  assign seg_next = blank ? 8'hFF : ~{1'b0, hexdec(nibble)};

  always_ff @(posedge clk) begin
    if (!rst || !ena) begin
      o_seg <= 8'hFF;
      o_sel <= '1;
    end else begin
      o_seg <= seg_next;
      o_sel <= ~(DIGITS'(1) << digit_idx);
    end
  end

endmodule
